// File: rtl/buffer_reader_pkg.sv
// Shared types and widths for the ping-pong buffer read-side drain engine.
package buffer_reader_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, END, GUARD} readerState_t;

  localparam int HOST_WORD_W = 16;
  localparam int SAMPLE_W    = 10;
  localparam int PAD_W       = 5;

  function automatic logic [HOST_WORD_W-1:0] packWord(input logic ovf,
                                                      input logic [SAMPLE_W-1:0] sample);
    return {ovf, {PAD_W{1'b0}}, sample};
  endfunction

endpackage

// File: rtl/buffer_reader_sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing into the local clock.
module sync_2ff (
  input  logic clock,
  input  logic nReset,
  input  logic asyncIn,
  output logic syncOut
);

  logic meta;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      meta    <= 1'b0;
      syncOut <= 1'b0;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/buffer_reader.sv
// Drains one full ping-pong buffer per dataAvailable event into the host FIFO.
// Optional BUFFER_READER_TEST_PATTERN_EN adds testMode, replacing samples with a counter.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int BURST_WORDS  = 8192,
  parameter int COUNT_W      = 14,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                   readClock,
  input  logic                   nReset,
  input  logic                   transferEnable,
`ifdef BUFFER_READER_TEST_PATTERN_EN
  input  logic                   testMode,
`endif
  input  logic                   dataAvailable,
  input  logic                   bufferOverflow,
  input  logic [SAMPLE_W-1:0]    sampleIn,
  output logic                   isReading,
  input  logic                   hostReady,
  output logic                   hostWrite,
  output logic [HOST_WORD_W-1:0] hostData,
  output logic                   hostPacketEnd,
  output logic                   busy
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  readerState_t        state, nextState;
  logic [COUNT_W-1:0]  reqCount, outCount;
  logic [GUARD_W-1:0]  guardCount;
  logic                inFlight, skidFull;
  logic [SAMPLE_W-1:0] skidData, wordSample;
  logic                ovfSync, startBurst, emitSkid, captureSkid;

  sync_2ff ovfSyncInst (
    .clock   (readClock),
    .nReset  (nReset),
    .asyncIn (bufferOverflow),
    .syncOut (ovfSync)
  );

`ifdef BUFFER_READER_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] patternCount;

  always_ff @(posedge readClock or negedge nReset) begin
    if (!nReset)         patternCount <= '0;
    else if (startBurst) patternCount <= '0;
    else if (hostWrite)  patternCount <= patternCount + 1'b1;
  end
`endif

  always_comb begin
    nextState     = state;
    isReading     = 1'b0;
    hostWrite     = 1'b0;
    hostPacketEnd = 1'b0;
    startBurst    = 1'b0;
    emitSkid      = 1'b0;
    captureSkid   = 1'b0;
    wordSample    = skidFull ? skidData : sampleIn;
`ifdef BUFFER_READER_TEST_PATTERN_EN
    if (testMode) wordSample = patternCount;
`endif
    case (state)
      IDLE: begin
        if (transferEnable && dataAvailable) begin
          startBurst = 1'b1;
          nextState  = STREAM;
        end
      end
      STREAM: begin
        // A pending skid word blocks new requests, so it never coexists with an in-flight one.
        emitSkid    = skidFull && hostReady;
        captureSkid = inFlight && !hostReady;
        isReading   = (reqCount != '0) && hostReady && !skidFull;
        hostWrite   = emitSkid || (inFlight && hostReady);
        if (hostWrite && outCount == COUNT_W'(1)) nextState = END;
      end
      END: begin
        hostPacketEnd = 1'b1;
        nextState     = GUARD;
      end
      GUARD: begin
        if (guardCount == GUARD_W'(GUARD_CYCLES - 1)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    hostData = hostWrite ? packWord(ovfSync, wordSample) : '0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge readClock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      reqCount   <= '0;
      outCount   <= '0;
      guardCount <= '0;
      inFlight   <= 1'b0;
      skidFull   <= 1'b0;
      skidData   <= '0;
    end else begin
      state    <= nextState;
      inFlight <= isReading;
      if (startBurst) begin
        reqCount <= COUNT_W'(BURST_WORDS);
        outCount <= COUNT_W'(BURST_WORDS);
      end else begin
        if (isReading) reqCount <= reqCount - 1'b1;
        if (hostWrite && outCount != '0) outCount <= outCount - 1'b1;
      end
      if (captureSkid) begin
        skidFull <= 1'b1;
        skidData <= sampleIn;
      end else if (emitSkid) begin
        skidFull <= 1'b0;
      end
      if (state != GUARD) guardCount <= '0;
      else                guardCount <= guardCount + 1'b1;
    end
  end

endmodule
